issue_sched: RTL and testbench
==============================

ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 Parameter: DEPTH, 8, number of issue-queue entries (power of 2, 4..16).
REQ-002 Parameter: PREG_W, 6, physical register tag width (64 physical registers).
REQ-003 Parameter: AGE_W, 8, instruction age tag width (from rename instr counter, wraps).
REQ-004 Parameter: PAYLOAD_W, 64, opaque renamed-instruction payload width.
REQ-005 clk  input  1  clock, all state rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 enq_valid  input  1  renamed instruction offered by rename stage.
REQ-008 enq_ready  output  1  queue accepts enqueue this cycle.
REQ-009 enq_rs_preg / enq_rt_preg  input  PREG_W each  source physical tags.
REQ-010 enq_rs_rdy / enq_rt_rdy  input  1 each  source ready at rename (unused source driven 1).
REQ-011 enq_age  input  AGE_W  instruction age tag; enq_payload  input  PAYLOAD_W  payload.
REQ-012 wb_valid  input  1  writeback broadcast; wb_preg  input  PREG_W  tag now ready.
REQ-013 iss_valid  output  1  oldest ready entry presented; iss_ready  input  1  execute accepts.
REQ-014 iss_age  output  AGE_W; iss_payload  output  PAYLOAD_W  of presented entry.
REQ-015 flush  input  1  mispredict squash; flush_age  input  AGE_W  age of mispredicted branch.
REQ-016 count  output  $clog2(DEPTH)+1  valid entries held.

Function
REQ-017 Entries held in a collapsing queue: index 0 oldest, new entries written at index count (after compaction).
REQ-018 Enqueue on enq_valid & enq_ready; entry visible to select the following cycle (1-cycle min latency).
REQ-019 enq_ready = (count < DEPTH) & !flush; no same-cycle credit from an issuing entry.
REQ-020 Wakeup: wb_valid sets rs_rdy/rt_rdy of every valid entry whose tag equals wb_preg, registered, effective next cycle.
REQ-021 Wakeup applies to an entry enqueued in the same cycle (enq tag == wb_preg -> stored ready).
REQ-022 Select: iss_valid = lowest-index valid entry with both ready bits set; iss_* driven combinationally from that entry.
REQ-023 Dequeue on iss_valid & iss_ready; entries above shift down one position, order preserved.
REQ-024 Simultaneous enqueue and dequeue: both occur, count unchanged, new entry placed at count-1.
REQ-025 Age compare modular: entry younger iff (entry_age - flush_age) mod 2^AGE_W in [1, 2^(AGE_W-1)-1].
REQ-026 flush: iss_valid forced 0, enqueue blocked, all younger entries invalidated at clock edge; older entries and entry equal to flush_age retained and compacted, order preserved.
REQ-027 flush with wb_valid same cycle: wakeup still applied to retained entries.
REQ-028 count always equals number of valid entries; never exceeds DEPTH; enq_valid while full ignored.

Reset
REQ-029 rst_n low: all entries invalid, ready bits 0, count=0, iss_valid=0, enq_ready=1 (once flush low), iss_age/iss_payload=0.
REQ-030 Reset mid-operation discards all entries immediately; no issue in first cycle after release unless enqueued prior cycle.

Configuration
REQ-031 Macro ISSUE_SCHED_WB_BYPASS_EN defined: select also treats a source as ready if wb_valid & wb_preg matches it this cycle (same-cycle wake and issue).
REQ-032 Macro undefined: woken entry eligible no earlier than cycle after broadcast (REQ-020 only).

Verification
REQ-033 Enqueue ages 5,6,7 all ready, iss_ready=1 -> issue order 5,6,7 on consecutive cycles, count 3->0.
REQ-034 Enqueue age 10 rs=preg 40 not ready, then age 11 ready -> 11 issues first; wb_preg=40 -> 10 issues next cycle (same cycle with bypass macro).
REQ-035 Fill 8 entries none ready -> enq_ready=0, 9th enq_valid dropped, count=8.
REQ-036 Ages 250,254,1,3 queued, flush_age=254 -> 1 and 3 removed, 250 and 254 retained, count=2.
REQ-037 Enqueue rs=preg 12 with wb_preg=12 same cycle -> entry issues next cycle without further broadcast.
REQ-038 Assert rst_n low with 5 entries queued -> count=0, iss_valid=0 same cycle, enq_ready=1.

Source files
------------

// File: rtl/issue_sched.sv
`default_nettype none
// issue_sched: collapsing age-ordered issue queue with tag wakeup, oldest-ready select and age-based flush.
// Define ISSUE_SCHED_WB_BYPASS_EN to let select see this cycle's writeback tag (same-cycle wake and issue).
module issue_sched #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 6,
  parameter int AGE_W     = 8,
  parameter int PAYLOAD_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [PREG_W-1:0]        enq_rs_preg_i,
  input  logic [PREG_W-1:0]        enq_rt_preg_i,
  input  logic                     enq_rs_rdy_i,
  input  logic                     enq_rt_rdy_i,
  input  logic [AGE_W-1:0]         enq_age_i,
  input  logic [PAYLOAD_W-1:0]     enq_payload_i,
  input  logic                     wb_valid_i,
  input  logic [PREG_W-1:0]        wb_preg_i,
  output logic                     iss_valid_o,
  input  logic                     iss_ready_i,
  output logic [AGE_W-1:0]         iss_age_o,
  output logic [PAYLOAD_W-1:0]     iss_payload_o,
  input  logic                     flush_i,
  input  logic [AGE_W-1:0]         flush_age_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_IDX_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     rs_rdy_q, rs_rdy_d;
  logic [DEPTH-1:0]     rt_rdy_q, rt_rdy_d;
  logic [PREG_W-1:0]    rs_preg_q [DEPTH];
  logic [PREG_W-1:0]    rs_preg_d [DEPTH];
  logic [PREG_W-1:0]    rt_preg_q [DEPTH];
  logic [PREG_W-1:0]    rt_preg_d [DEPTH];
  logic [AGE_W-1:0]     age_q     [DEPTH];
  logic [AGE_W-1:0]     age_d     [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [DEPTH];
  logic [c_CNT_W-1:0]   count_q, count_d;

  logic [DEPTH-1:0]     rs_hit, rt_hit, rs_ok, rt_ok, keep;
  logic                 sel_found;
  logic [c_IDX_W-1:0]   sel_idx;
  logic                 deq, enq_fire;
  logic                 enq_rs_rdy_w, enq_rt_rdy_w;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_hit[i] = wb_valid_i && (rs_preg_q[i] == wb_preg_i);
      rt_hit[i] = wb_valid_i && (rt_preg_q[i] == wb_preg_i);
`ifdef ISSUE_SCHED_WB_BYPASS_EN
      rs_ok[i]  = rs_rdy_q[i] | rs_hit[i];
      rt_ok[i]  = rt_rdy_q[i] | rt_hit[i];
`else
      rs_ok[i]  = rs_rdy_q[i];
      rt_ok[i]  = rt_rdy_q[i];
`endif
    end
  end

  // Scan from the top so the last hit written is the lowest (oldest) index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && rs_ok[i] && rt_ok[i]) begin
        sel_found = 1'b1;
        sel_idx   = c_IDX_W'(i);
      end
    end
  end

  assign iss_valid_o   = sel_found & ~flush_i;
  assign iss_age_o     = iss_valid_o ? age_q[sel_idx]     : '0;
  assign iss_payload_o = iss_valid_o ? payload_q[sel_idx] : '0;
  assign deq           = iss_valid_o & iss_ready_i;
  assign enq_ready_o   = (count_q < c_DEPTH) & ~flush_i;
  assign enq_fire      = enq_valid_i & enq_ready_o;
  assign count_o       = count_q;
  assign enq_rs_rdy_w  = enq_rs_rdy_i | (wb_valid_i && (enq_rs_preg_i == wb_preg_i));
  assign enq_rt_rdy_w  = enq_rt_rdy_i | (wb_valid_i && (enq_rt_preg_i == wb_preg_i));

  // Younger iff (age - flush_age) mod 2^AGE_W lies in [1, 2^(AGE_W-1)-1].
  always_comb begin
    logic [AGE_W-1:0] age_diff;
    for (int i = 0; i < DEPTH; i++) begin
      age_diff = age_q[i] - flush_age_i;
      keep[i]  = valid_q[i]
                 && !(flush_i && (age_diff != '0) && !age_diff[AGE_W-1])
                 && !(deq && (sel_idx == c_IDX_W'(i)));
    end
  end

  // Compaction: surviving entries pack down in order, then the new entry lands on top.
  always_comb begin
    logic [c_CNT_W-1:0] n;
    n        = '0;
    valid_d  = '0;
    rs_rdy_d = '0;
    rt_rdy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_preg_d[i] = '0;
      rt_preg_d[i] = '0;
      age_d[i]     = '0;
      payload_d[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        valid_d[n[c_IDX_W-1:0]]   = 1'b1;
        rs_rdy_d[n[c_IDX_W-1:0]]  = rs_rdy_q[i] | rs_hit[i];
        rt_rdy_d[n[c_IDX_W-1:0]]  = rt_rdy_q[i] | rt_hit[i];
        rs_preg_d[n[c_IDX_W-1:0]] = rs_preg_q[i];
        rt_preg_d[n[c_IDX_W-1:0]] = rt_preg_q[i];
        age_d[n[c_IDX_W-1:0]]     = age_q[i];
        payload_d[n[c_IDX_W-1:0]] = payload_q[i];
        n = n + c_ONE;
      end
    end
    if (enq_fire) begin
      valid_d[n[c_IDX_W-1:0]]   = 1'b1;
      rs_rdy_d[n[c_IDX_W-1:0]]  = enq_rs_rdy_w;
      rt_rdy_d[n[c_IDX_W-1:0]]  = enq_rt_rdy_w;
      rs_preg_d[n[c_IDX_W-1:0]] = enq_rs_preg_i;
      rt_preg_d[n[c_IDX_W-1:0]] = enq_rt_preg_i;
      age_d[n[c_IDX_W-1:0]]     = enq_age_i;
      payload_d[n[c_IDX_W-1:0]] = enq_payload_i;
      n = n + c_ONE;
    end
    count_d = n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rs_preg_q[i] <= '0;
        rt_preg_q[i] <= '0;
        age_q[i]     <= '0;
        payload_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      rs_rdy_q  <= rs_rdy_d;
      rt_rdy_q  <= rt_rdy_d;
      count_q   <= count_d;
      rs_preg_q <= rs_preg_d;
      rt_preg_q <= rt_preg_d;
      age_q     <= age_d;
      payload_q <= payload_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_sched.sv
`default_nettype none
// tb_issue_sched: directed self-checking bench for issue_sched.
module tb_issue_sched;

  localparam int DEPTH = 8, PREG_W = 6, AGE_W = 8, PAYLOAD_W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 enq_valid, enq_ready, enq_rs_rdy, enq_rt_rdy;
  logic [PREG_W-1:0]    enq_rs_preg, enq_rt_preg, wb_preg;
  logic [AGE_W-1:0]     enq_age, iss_age, flush_age;
  logic [PAYLOAD_W-1:0] enq_payload, iss_payload;
  logic                 wb_valid, iss_valid, iss_ready, flush;
  logic [$clog2(DEPTH):0] count;

  issue_sched #(.DEPTH(DEPTH), .PREG_W(PREG_W), .AGE_W(AGE_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
    .enq_rs_preg_i(enq_rs_preg), .enq_rt_preg_i(enq_rt_preg),
    .enq_rs_rdy_i(enq_rs_rdy), .enq_rt_rdy_i(enq_rt_rdy),
    .enq_age_i(enq_age), .enq_payload_i(enq_payload),
    .wb_valid_i(wb_valid), .wb_preg_i(wb_preg),
    .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
    .iss_age_o(iss_age), .iss_payload_o(iss_payload),
    .flush_i(flush), .flush_age_i(flush_age),
    .count_o(count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pl(input logic [7:0] a);
    return {56'hC0FFEE00000000, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] age, input logic [5:0] rs, input logic rsr,
                     input logic [5:0] rt, input logic rtr);
    enq_valid   = 1'b1;
    enq_age     = age;
    enq_rs_preg = rs;
    enq_rs_rdy  = rsr;
    enq_rt_preg = rt;
    enq_rt_rdy  = rtr;
    enq_payload = pl(age);
  endtask

  initial begin
    rst_n = 1'b0; enq_valid = 1'b0; enq_rs_rdy = 1'b0; enq_rt_rdy = 1'b0;
    enq_rs_preg = '0; enq_rt_preg = '0; enq_age = '0; enq_payload = '0;
    wb_valid = 1'b0; wb_preg = '0; iss_ready = 1'b0; flush = 1'b0; flush_age = '0;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_enq_ready", 64'(enq_ready), 1);
    chk("rst_iss_age", 64'(iss_age), 0);
    chk("rst_iss_payload", iss_payload, 0);
    #12 rst_n = 1'b1;
    tick();

    // In-order issue of three ready entries
    put(5, 1, 1, 2, 1); tick();
    put(6, 1, 1, 2, 1); tick();
    put(7, 1, 1, 2, 1); tick();
    enq_valid = 1'b0; #1;
    chk("order_count3", 64'(count), 3);
    chk("order_age5", 64'(iss_age), 5);
    chk("order_payload5", iss_payload, pl(5));
    iss_ready = 1'b1; tick();
    chk("order_age6", 64'(iss_age), 6);
    chk("order_count2", 64'(count), 2);
    tick();
    chk("order_age7", 64'(iss_age), 7);
    chk("order_count1", 64'(count), 1);
    tick();
    chk("order_count0", 64'(count), 0);
    chk("order_empty_valid", 64'(iss_valid), 0);
    iss_ready = 1'b0;

    // Younger ready entry bypasses older blocked one; wakeup releases the older
    put(10, 40, 0, 3, 1); tick();
    put(11, 4, 1, 5, 1); tick();
    enq_valid = 1'b0; iss_ready = 1'b1; #1;
    chk("wake_first_valid", 64'(iss_valid), 1);
    chk("wake_first_age", 64'(iss_age), 11);
    tick();
    chk("wake_count1", 64'(count), 1);
    chk("wake_blocked", 64'(iss_valid), 0);
    wb_valid = 1'b1; wb_preg = 40; #1;
`ifdef ISSUE_SCHED_WB_BYPASS_EN
    chk("wake_bypass_valid", 64'(iss_valid), 1);
    chk("wake_bypass_age", 64'(iss_age), 10);
    tick();
    wb_valid = 1'b0; #1;
    chk("wake_bypass_count0", 64'(count), 0);
`else
    chk("wake_nobypass_valid", 64'(iss_valid), 0);
    tick();
    wb_valid = 1'b0; #1;
    chk("wake_next_valid", 64'(iss_valid), 1);
    chk("wake_next_age", 64'(iss_age), 10);
    tick();
    chk("wake_count0", 64'(count), 0);
`endif
    iss_ready = 1'b0;

    // Fill to capacity; excess enqueue dropped
    for (int i = 0; i < DEPTH; i++) begin
      put(8'(20 + i), 6'(20 + i), 0, 1, 1);
      tick();
    end
    put(99, 1, 1, 2, 1); #1;
    chk("full_enq_ready", 64'(enq_ready), 0);
    chk("full_count", 64'(count), 8);
    tick();
    enq_valid = 1'b0; #1;
    chk("full_drop_count", 64'(count), 8);
    wb_valid = 1'b1; wb_preg = 22; tick();
    wb_valid = 1'b0; #1;
    chk("mid_wake_valid", 64'(iss_valid), 1);
    chk("mid_wake_age", 64'(iss_age), 22);
    flush = 1'b1; flush_age = 19; #1;
    chk("flush_forces_iss", 64'(iss_valid), 0);
    chk("flush_blocks_enq", 64'(enq_ready), 0);
    tick();
    flush = 1'b0; #1;
    chk("flush_all_count", 64'(count), 0);

    // Modular-age flush across wrap, with concurrent wakeup of survivors
    put(250, 50, 0, 1, 1); tick();
    put(254, 50, 0, 1, 1); tick();
    put(1, 50, 0, 1, 1); tick();
    put(3, 50, 0, 1, 1); tick();
    enq_valid = 1'b0; #1;
    chk("wrap_count4", 64'(count), 4);
    flush = 1'b1; flush_age = 254; wb_valid = 1'b1; wb_preg = 50; tick();
    flush = 1'b0; wb_valid = 1'b0; #1;
    chk("wrap_count2", 64'(count), 2);
    chk("wrap_woken_valid", 64'(iss_valid), 1);
    chk("wrap_head_age", 64'(iss_age), 250);
    iss_ready = 1'b1; tick();
    chk("wrap_second_age", 64'(iss_age), 254);
    chk("wrap_second_payload", iss_payload, pl(254));
    tick();
    chk("wrap_drained", 64'(count), 0);
    iss_ready = 1'b0;

    // Wakeup on the enqueue cycle, then simultaneous enqueue and dequeue
    put(40, 12, 0, 1, 1); wb_valid = 1'b1; wb_preg = 12; tick();
    enq_valid = 1'b0; wb_valid = 1'b0; #1;
    chk("enqwake_valid", 64'(iss_valid), 1);
    chk("enqwake_age", 64'(iss_age), 40);
    put(41, 2, 1, 3, 1); iss_ready = 1'b1; #1;
    chk("simul_enq_ready", 64'(enq_ready), 1);
    tick();
    enq_valid = 1'b0; #1;
    chk("simul_count", 64'(count), 1);
    chk("simul_age", 64'(iss_age), 41);
    tick();
    chk("simul_drained", 64'(count), 0);
    iss_ready = 1'b0;

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) begin
      put(8'(60 + i), 6'(30 + i), 0, 1, 1);
      tick();
    end
    enq_valid = 1'b0; #1;
    chk("pre_reset_count", 64'(count), 5);
    rst_n = 1'b0; #1;
    chk("async_rst_count", 64'(count), 0);
    chk("async_rst_valid", 64'(iss_valid), 0);
    chk("async_rst_enq_ready", 64'(enq_ready), 1);
    chk("async_rst_age", 64'(iss_age), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 64'(iss_valid), 0);
    chk("post_rst_count", 64'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
